// File: rtl/oam_port_arbiter.sv
// OAM port arbiter: shares one single-port OAM RAM between the sprite scanner
// (read-only, priority) and the CPU bridge (read/write). A starvation counter
// forces a CPU grant after STARVE_LIMIT consecutive waiting cycles.
// Optional build macro OAM_CPU_BLOCK_DURING_SCAN_EN adds scan_active_i, which
// blocks CPU writes (and freezes the starvation counter) during line scans.
module oam_port_arbiter #(
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              scan_req_i,
    input  logic [ADDR_W-1:0] scan_addr_i,
`ifdef OAM_CPU_BLOCK_DURING_SCAN_EN
    input  logic              scan_active_i,
`endif
    output logic              scan_gnt_o,
    output logic              scan_rvalid_o,
    output logic [DATA_W-1:0] scan_rdata_o,
    input  logic              cpu_valid_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ready_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(STARVE_LIMIT - 1);

    // Who owns the read data returning from the RAM this cycle.
    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnScan = 2'd1,
        OwnCpu  = 2'd2
    } owner_e;

    owner_e            owner_q, owner_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              force_q, force_d;
    logic [DATA_W-1:0] scan_rdata_q, scan_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    logic cpu_blocked;
    logic cpu_elig;

`ifdef OAM_CPU_BLOCK_DURING_SCAN_EN
    assign cpu_blocked = scan_active_i & cpu_we_i;
`else
    assign cpu_blocked = 1'b0;
`endif

    // A blocked write is invisible to arbitration; reads are never blocked.
    assign cpu_elig = cpu_valid_i & ~cpu_blocked;

    // Grant selection and RAM drive.
    always_comb begin
        scan_gnt_o  = 1'b0;
        cpu_ready_o = 1'b0;
        if (force_q && cpu_elig) begin
            cpu_ready_o = 1'b1;
        end else if (scan_req_i) begin
            scan_gnt_o = 1'b1;
        end else if (cpu_elig) begin
            cpu_ready_o = 1'b1;
        end

        ram_addr_o = '0;
        if (scan_gnt_o) begin
            ram_addr_o = scan_addr_i;
        end else if (cpu_ready_o) begin
            ram_addr_o = cpu_addr_i;
        end
        ram_we_o    = cpu_ready_o & cpu_we_i;
        ram_wdata_o = cpu_wdata_i;
    end

    // Next-state: read owner, starvation counter, forced grant, held read data.
    always_comb begin
        owner_d = OwnNone;
        if (scan_gnt_o) begin
            owner_d = OwnScan;
        end else if (cpu_ready_o && !cpu_we_i) begin
            owner_d = OwnCpu;
        end

        cnt_d   = cnt_q;
        force_d = force_q;
        if (!cpu_valid_i) begin
            // Also covers a withdrawn request, so a stale force never lingers.
            cnt_d   = '0;
            force_d = 1'b0;
        end else if (cpu_blocked) begin
            cnt_d   = cnt_q;
            force_d = force_q;
        end else if (cpu_ready_o) begin
            cnt_d   = '0;
            force_d = 1'b0;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
                force_d = 1'b1;
            end
        end

        scan_rdata_d = scan_rdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        if (owner_q == OwnScan) begin
            scan_rdata_d = ram_rdata_i;
        end
        if (owner_q == OwnCpu) begin
            cpu_rdata_d = ram_rdata_i;
        end
    end

    // Read-return outputs: live RAM data on the return cycle, held value otherwise.
    always_comb begin
        scan_rvalid_o = (owner_q == OwnScan);
        cpu_rvalid_o  = (owner_q == OwnCpu);
        scan_rdata_o  = scan_rvalid_o ? ram_rdata_i : scan_rdata_q;
        cpu_rdata_o   = cpu_rvalid_o ? ram_rdata_i : cpu_rdata_q;
    end

    // State registers; reset drops any in-flight read return.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            owner_q      <= OwnNone;
            cnt_q        <= '0;
            force_q      <= 1'b0;
            scan_rdata_q <= '0;
            cpu_rdata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            force_q      <= force_d;
            scan_rdata_q <= scan_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

endmodule

// File: doc/oam_port_arbiter.md
Name: oam_port_arbiter

Overview:
- Shares the single-port 64x32 OAM RAM between two requesters: the per-scanline sprite scanner (reads) and the CPU bus bridge (reads/writes).
- Scanner has priority so line preparation finishes within the line budget.
- Bounded-starvation guard guarantees CPU progress.
- Sits between the OAM RAM, the scanline sprite-evaluation stage and the memory-mapped CPU interface.

Parameters:
- ADDR_W, 6, OAM word address width (64 entries)
- DATA_W, 32, OAM word width
- STARVE_LIMIT, 8, consecutive cycles a pending CPU request may wait before forced grant (range 2..255)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- scan_req  in  1  scanner requests a read this cycle
- scan_addr  in  ADDR_W  scanner read address
- scan_gnt  out  1  scanner read accepted this cycle (combinational)
- scan_rvalid  out  1  scan_rdata valid (one cycle after grant)
- scan_rdata  out  DATA_W  scanner read data
- cpu_valid  in  1  CPU request pending; addr/we/wdata held stable until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  CPU request accepted this cycle (combinational)
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after a read grant)
- cpu_rdata  out  DATA_W  CPU read data
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, registered, 1-cycle latency

Behaviour:
- Per-cycle grant, evaluated in priority order:
  - force_cpu && cpu_valid -> CPU
  - else scan_req -> scanner
  - else cpu_valid -> CPU
  - else idle
- Exactly one of scan_gnt/cpu_ready is high, or neither. Never both.
- RAM drive:
  - ram_addr = granted requester's address; 0 when idle.
  - ram_we = cpu_ready && cpu_we.
  - ram_wdata = cpu_wdata.
- Read-return pipeline: a 2-bit owner register records the previous cycle's read grant (NONE/SCAN/CPU).
  - Cycle after a scanner grant: scan_rvalid=1, scan_rdata=ram_rdata.
  - Cycle after a CPU read grant: cpu_rvalid=1, cpu_rdata=ram_rdata.
  - CPU writes produce no rvalid.
  - Both rdata outputs hold their last value while the matching rvalid=0.
- Back-to-back grants are allowed, one per cycle; sustained throughput is 1 access/cycle.
- Starvation counter, width ceil(log2(STARVE_LIMIT))+1:
  - Increments each cycle cpu_valid && !cpu_ready.
  - Clears on cpu_ready or when !cpu_valid.
  - force_cpu is registered: set when the counter reaches STARVE_LIMIT-1 on an incrementing cycle; cleared the cycle after the CPU grant.
- During a forced CPU cycle scan_gnt=0. The scanner holds scan_req/scan_addr and retries the next cycle.
- Ordering:
  - A CPU write granted in cycle N is visible to any read granted in cycle N+1 or later.
  - No read-during-write case exists (single port, single grant).
- Deasserting cpu_valid before cpu_ready is a protocol violation; the arbiter must not lock up, and the counter clears.
- Reset (asynchronous, any time, including mid-transfer):
  - Outputs: scan_rvalid=0, cpu_rvalid=0, scan_rdata=0, cpu_rdata=0.
  - Internal state: owner=NONE, counter=0, force_cpu=0.
  - Any in-flight read return is dropped, never delivered after reset deassertion.
  - Combinational outputs with no requests: scan_gnt=0, cpu_ready=0, ram_we=0, ram_addr=0.

Optional Feature:
- Macro: OAM_CPU_BLOCK_DURING_SCAN_EN
- Defined:
  - Adds input scan_active (1 bit).
  - While scan_active=1, CPU writes are never granted: no forced grant, and the counter is frozen but not cleared.
  - CPU reads keep normal arbitration. This gives the scanner a stable OAM snapshot per line.
  - Writes resume when scan_active=0.
- Undefined:
  - No scan_active port.
  - Writes arbitrate like reads, as above.

Test Plan:
- Reset with no requests -> all outputs 0.
- Scanner-only run:
  - Stimulus: scan_req=1 for 64 cycles, addresses 0..63; RAM preloaded with word[i]=0xA5000000+i.
  - Required: scan_gnt=1 every cycle; scan_rvalid cycles 1..64 with matching data.
- CPU write then read:
  - Stimulus: write 0xDEADBEEF to addr 5, idle scanner; then read addr 5.
  - Required: cpu_ready same cycle as each request; cpu_rvalid one cycle after the read with 0xDEADBEEF.
- Starvation:
  - Stimulus: scan_req held continuously, CPU write pending from cycle 0, STARVE_LIMIT=8.
  - Required: cpu_ready=1 exactly once at cycle 8, scan_gnt=0 that cycle, scanner resumes cycle 9; no lost scanner address.
- Reset mid-read:
  - Stimulus: scanner grant in cycle N, reset asserted in cycle N+1 before the clock edge.
  - Required: scan_rvalid=0 throughout and after reset.
- Feature on:
  - Stimulus: scan_active=1, CPU write pending, scan_req=1 for 20 cycles.
  - Required: no cpu_ready for 20 cycles; scan_active dropped -> cpu_ready within 1 cycle of scan_req=0.
